// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave):
// a request phase closed by gnt and a read-data phase closed by rvalid.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [31:0]           bus_wdata;
    logic [3:0]            bus_be;
    logic                  bus_gnt;
    logic                  bus_rvalid;
    logic [31:0]           bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding req/gnt/rvalid transaction at a time, with
// store lane steering and sign/zero extension of load data.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mem_op,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic [DATA_WIDTH-1:0] Mem_ReadData,
    output logic                  lsu_busy,
    output logic                  lsu_done,
    output logic                  lsu_err,
    load_store_unit_if.master     bus
);
    typedef enum logic [2:0] {IDLE, REQ, RWAIT, DONE, ERR} state_t;

    state_t      state_q;
    logic        is_load_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;

    logic        is_ld, is_st, illegal, misal;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] rdata_d;

    always_comb begin
        is_ld   = (mem_op == 2'b01);
        is_st   = (mem_op == 2'b10);
        illegal = is_ld ? (funct3 == 3'b011 || funct3[2:1] == 2'b11)
                        : (funct3[2] || funct3[1:0] == 2'b11);
        // Width comes from funct3[1:0] for both signed and unsigned loads
        misal   = (funct3[1:0] == 2'b01 && addr[0]) ||
                  (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        be_d    = 4'b1111;
        wdata_d = '0;
        if (is_st) begin
            case (funct3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << addr[1:0];
                    wdata_d = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be_d    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{store_data[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = store_data;
                end
            endcase
        end
    end

    always_comb begin
        rbyte = 8'(bus.bus_rdata >> {off_q, 3'b000});
        rhalf = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (f3_q)
            3'b000:  rdata_d = {{24{rbyte[7]}}, rbyte};
            3'b100:  rdata_d = {24'b0, rbyte};
            3'b001:  rdata_d = {{16{rhalf[15]}}, rhalf};
            3'b101:  rdata_d = {16'b0, rhalf};
            default: rdata_d = bus.bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            is_load_q     <= 1'b0;
            off_q         <= '0;
            f3_q          <= '0;
            Mem_ReadData  <= '0;
            lsu_busy      <= 1'b0;
            lsu_done      <= 1'b0;
            lsu_err       <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_be    <= '0;
        end else begin
            lsu_done <= 1'b0;
            lsu_err  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && (is_ld || is_st)) begin
                        is_load_q     <= is_ld;
                        off_q         <= addr[1:0];
                        f3_q          <= funct3;
                        bus.bus_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        bus.bus_we    <= is_st;
                        bus.bus_be    <= be_d;
                        bus.bus_wdata <= wdata_d;
                        if (illegal || misal) begin
                            state_q  <= ERR;
                            lsu_done <= 1'b1;
                            lsu_err  <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            bus.bus_req <= 1'b1;
                            lsu_busy    <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus.bus_gnt) begin
                        bus.bus_req <= 1'b0;
                        if (!is_load_q || bus.bus_rvalid) begin
                            if (is_load_q) Mem_ReadData <= rdata_d;
                            state_q  <= DONE;
                            lsu_done <= 1'b1;
                            lsu_busy <= 1'b0;
                        end else begin
                            state_q <= RWAIT;
                        end
                    end
                end
                RWAIT: begin
                    if (bus.bus_rvalid) begin
                        Mem_ReadData <= rdata_d;
                        state_q      <= DONE;
                        lsu_done     <= 1'b1;
                        lsu_busy     <= 1'b0;
                    end
                end
                DONE:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
